// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 5-stage 16-bit pipeline.
// Holds the PC register and the IF/ID pipeline register, and optionally a
// direct-mapped branch predictor (BTB plus 2-bit saturating counters).
// Optional feature macro: FETCH_BRANCH_PRED_EN (predictor present when defined).
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          BTB_IDX_W = 3,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PC_stall,
  input  logic        IF_ID_stall,
  input  logic        IF_flush,
  input  logic        update_PC,
  input  logic [15:0] actual_target,
  input  logic        br_resolve,
  input  logic [15:0] br_resolve_PC,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] PC_curr,
  output logic [15:0] IF_ID_PC_next,
  output logic [15:0] IF_ID_instr,
  output logic        IF_ID_pred_taken,
  output logic [15:0] IF_ID_pred_target
);

  localparam int TAG_W   = 15 - BTB_IDX_W;
  localparam int ENTRIES = 1 << BTB_IDX_W;

  logic [15:0] pc_r;
  logic [15:0] pc_plus2_s;
  logic [15:0] pc_next_s;
  logic        pred_taken_s;
  logic [15:0] pred_target_s;

  // The PC is word-aligned; bit 0 never selects anything, it simply wraps along.
  assign pc_plus2_s = pc_r + 16'd2;
  assign imem_addr  = pc_r;
  assign PC_curr    = pc_r;

`ifdef FETCH_BRANCH_PRED_EN
  // 2-bit saturating counter step: taken counts up, not-taken counts down.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (ctr == 2'b11) ? ctr : ctr + 2'b01;
    end else begin
      res = (ctr == 2'b00) ? ctr : ctr - 2'b01;
    end
    return res;
  endfunction

  logic               valid_r  [ENTRIES];
  logic [TAG_W-1:0]   tag_r    [ENTRIES];
  logic [15:0]        target_r [ENTRIES];
  logic [1:0]         ctr_r    [ENTRIES];

  logic [BTB_IDX_W-1:0] look_idx_s;
  logic [TAG_W-1:0]     look_tag_s;
  logic                 look_hit_s;
  logic [BTB_IDX_W-1:0] train_idx_s;
  logic [TAG_W-1:0]     train_tag_s;
  logic                 train_hit_s;
  logic                 unused_s;

  assign look_idx_s  = pc_r[BTB_IDX_W:1];
  assign look_tag_s  = pc_r[15:BTB_IDX_W+1];
  assign train_idx_s = br_resolve_PC[BTB_IDX_W:1];
  assign train_tag_s = br_resolve_PC[15:BTB_IDX_W+1];
  assign unused_s    = br_resolve_PC[0];

  // Lookup reads the pre-training state; there is deliberately no bypass.
  always_comb begin
    look_hit_s    = valid_r[look_idx_s] && (tag_r[look_idx_s] == look_tag_s);
    train_hit_s   = valid_r[train_idx_s] && (tag_r[train_idx_s] == train_tag_s);
    pred_taken_s  = look_hit_s & ctr_r[look_idx_s][1];
    pred_target_s = target_r[look_idx_s];
  end

  // Predictor training from the resolved branch; runs regardless of stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= {TAG_W{1'b0}};
        target_r[i] <= 16'h0000;
        ctr_r[i]    <= 2'b01;
      end
    end else if (br_resolve) begin
      if (train_hit_s) begin
        ctr_r[train_idx_s] <= sat_update(ctr_r[train_idx_s], br_taken);
        if (br_taken) begin
          target_r[train_idx_s] <= br_target;
        end
      end else if (br_taken) begin
        valid_r[train_idx_s]  <= 1'b1;
        tag_r[train_idx_s]    <= train_tag_s;
        target_r[train_idx_s] <= br_target;
        ctr_r[train_idx_s]    <= 2'b10;
      end
    end
  end
`else
  logic unused_s;

  // Without the predictor every fetch falls through; training inputs are ignored.
  assign pred_taken_s  = 1'b0;
  assign pred_target_s = 16'h0000;
  assign unused_s      = ^{br_resolve, br_resolve_PC, br_taken, br_target};
`endif

  // Next-PC selection: redirect beats stall, stall beats prediction.
  always_comb begin
    pc_next_s = pc_plus2_s;
    if (update_PC) begin
      pc_next_s = actual_target;
    end else if (PC_stall) begin
      pc_next_s = pc_r;
    end else if (pred_taken_s) begin
      pc_next_s = pred_target_s;
    end else begin
      pc_next_s = pc_plus2_s;
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  // IF/ID register: flush or redirect inserts a bubble and beats the stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IF_ID_instr       <= NOP_INSTR;
      IF_ID_PC_next     <= 16'h0000;
      IF_ID_pred_taken  <= 1'b0;
      IF_ID_pred_target <= 16'h0000;
    end else if (IF_flush || update_PC) begin
      IF_ID_instr       <= NOP_INSTR;
      IF_ID_PC_next     <= 16'h0000;
      IF_ID_pred_taken  <= 1'b0;
      IF_ID_pred_target <= 16'h0000;
    end else if (!IF_ID_stall) begin
      IF_ID_instr       <= imem_data;
      IF_ID_PC_next     <= pc_plus2_s;
      IF_ID_pred_taken  <= pred_taken_s;
      IF_ID_pred_target <= pred_target_s;
    end
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage 16-bit pipeline.
- Owns the PC register and the IF/ID pipeline register, with an optional direct-mapped branch predictor (BTB plus 2-bit counters).
- Consumes the stall/flush controls from hazard detection (PC_stall, IF_ID_stall, IF_flush) and the resolved-branch update from decode.
- Produces the fetched word, its PC+2 and its prediction for the decode stage.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- BTB_IDX_W, 3, log2 of predictor entry count (8 entries).
- NOP_INSTR, 16'h0000, word inserted into IF/ID on flush/reset (ADD $0,$0,$0).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- PC_stall  input  1  hold PC this cycle
- IF_ID_stall  input  1  hold IF/ID register this cycle
- IF_flush  input  1  load NOP into IF/ID this cycle
- update_PC  input  1  branch resolved in ID differs from prediction; redirect
- actual_target  input  16  correct next PC when update_PC=1
- br_resolve  input  1  decode resolved a branch this cycle (trains predictor)
- br_resolve_PC  input  16  PC of the resolved branch
- br_taken  input  1  resolved direction
- br_target  input  16  resolved taken target
- imem_addr  output  16  instruction memory address (= PC, combinational)
- imem_data  input  16  instruction word, combinational read of imem_addr
- PC_curr  output  16  current PC register
- IF_ID_PC_next  output  16  registered PC+2 of fetched instruction
- IF_ID_instr  output  16  registered instruction word
- IF_ID_pred_taken  output  1  registered prediction
- IF_ID_pred_target  output  16  registered predicted target

Behaviour:
- Reset (async, rst_n=0):
  - PC=RESET_PC, IF_ID_instr=NOP_INSTR, IF_ID_PC_next=0, IF_ID_pred_taken=0, IF_ID_pred_target=0.
  - All BTB valid bits=0; all counters=2'b01 (weakly not-taken).
  - Deassertion takes effect at the next rising edge.
- PC+2 is computed modulo 2^16; 16'hFFFE wraps to 16'h0000.
- Lookup (combinational):
  - idx=PC[BTB_IDX_W:1]; tag=PC[15:BTB_IDX_W+1].
  - hit = valid[idx] & tag match.
  - pred_taken = hit & counter[idx][1]; pred_target = btb_target[idx].
- Next-PC priority, highest first:
  1. update_PC → PC=actual_target. This overrides PC_stall.
  2. PC_stall → PC holds.
  3. pred_taken → PC=pred_target.
  4. else → PC=PC+2.
- IF/ID register priority:
  1. IF_flush or update_PC → instr=NOP_INSTR, pred_taken=0, PC_next/pred_target=0. Flush wins over IF_ID_stall.
  2. IF_ID_stall → all IF/ID fields hold.
  3. else → load imem_data, PC+2, pred_taken, pred_target.
- Predictor training, on the edge when br_resolve=1, using idx/tag of br_resolve_PC:
  - Entry miss and br_taken=1 → allocate: valid=1, tag written, target=br_target, counter=2'b10.
  - Entry miss and br_taken=0 → no allocation.
  - Entry hit → counter saturating ±1 (00↔11 bounds); target rewritten when br_taken=1.
  - Training is independent of stalls.
  - Same-cycle train and lookup on the same idx: lookup sees the pre-update state (no bypass).
- Latency: instruction at PC appears on IF_ID_instr one cycle after fetch. A misprediction costs exactly one bubble.
- HLT: handled upstream via PC_stall/IF_ID_stall. The PC freezes on the HLT word's successor indefinitely until reset.

Optional Feature:
- Macro: FETCH_BRANCH_PRED_EN.
- When defined: BTB and counters are instantiated as described above.
- When undefined:
  - No predictor storage; pred_taken is constant 0 and pred_target is constant 0.
  - Next PC is PC+2 unless update_PC or PC_stall.
  - br_resolve, br_resolve_PC, br_taken and br_target are ignored.

Test Plan:
- Reset with rst_n=0 mid-run at PC=16'h0040 → outputs immediately PC_curr=0000, IF_ID_instr=0000. After release, sequential fetch gives PC 0002, 0004; IF_ID_PC_next=0002 one cycle after fetching PC 0000.
- PC_stall=1 and IF_ID_stall=1 for 3 cycles at PC=0010 → PC_curr and IF_ID fields unchanged. Resume gives PC=0012.
- IF_flush=1 with IF_ID_stall=1 → IF_ID_instr=NOP_INSTR next cycle (flush wins).
- update_PC=1, actual_target=0100, while PC_stall=1 → PC=0100 next edge; IF_ID_instr=0000.
- Train br_resolve_PC=0020 taken to 0080 once, then fetch 0020 → pred_taken=1, next PC=0080. Train not-taken twice → counter 10→01→00; fetch 0020 → next PC 0022.
- Wrap: PC=FFFE, no prediction → next PC=0000, IF_ID_PC_next=0000. With the macro undefined, training at 0020 leaves fetch at 0020 → 0022.
